fifo_rd_burst_ctrl: RTL

//  Read-side pointer/flag controller for the single-clock AXI-stream FIFO, generalised to multi-word reads.

---
 rtl/fifo_ptr_pkg.sv | 23 ++
 rtl/ptr_bin2gray.sv | 21 ++
 rtl/fifo_rd_burst_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the FIFO read/write pointer blocks.
// Optional Gray-coded read pointer output is enabled by FIFO_RD_GRAY_PTR_EN.
package fifo_ptr_pkg;

  localparam int unsigned ALEN_DEF = 8;

  typedef logic [ALEN_DEF:0] ptr_t;

  // Width of a word-count field able to hold 0..max_rd.
  function automatic int unsigned rd_cnt_width(input int unsigned max_rd);
    return $clog2(max_rd + 1);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Pointer distance a - b; the caller truncates to the pointer width for the modulo.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/ptr_bin2gray.sv
// Registered binary-to-Gray converter for a pointer bus.
module ptr_bin2gray
  import fifo_ptr_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gray <= '0;
    end else begin
      gray <= W'(bin2gray(32'(bin)));
    end
  end

endmodule

// File: rtl/fifo_rd_burst_ctrl.sv
// Read-side pointer/flag controller with atomic multi-word read grants.
// Define FIFO_RD_GRAY_PTR_EN to add the registered Gray read-pointer output o_rptr_gray.
module fifo_rd_burst_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter  int unsigned ALEN          = 8,
  parameter  int unsigned MAX_RD        = 4,
  parameter  int unsigned AEMPTY_THRESH = 2,
  localparam int unsigned CW            = rd_cnt_width(MAX_RD),
  localparam int unsigned PW            = ALEN + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_ren,
  input  logic [CW-1:0]   i_rcnt,
  input  logic [PW-1:0]   i_wptr,
  input  logic            i_uflow_clr,
  output logic [ALEN-1:0] o_raddr,
  output logic [PW-1:0]   o_rptr,
  output logic            o_ram_ren,
  output logic [CW-1:0]   o_ram_rcnt,
  output logic [PW-1:0]   o_rlevel,
  output logic            o_rempty,
  output logic            o_raempty,
  output logic            o_runderflow
`ifdef FIFO_RD_GRAY_PTR_EN
  ,
  output logic [PW-1:0]   o_rptr_gray
`endif
);

  logic [31:0]   rcnt_w;
  logic [31:0]   level_w;
  logic          grant;
  logic          illegal;
  logic [PW-1:0] rptr_d;
  logic [PW-1:0] level_d;

  assign rcnt_w  = 32'(i_rcnt);
  assign level_w = 32'(o_rlevel);

  // Grant only whole requests that fit in the stored level; everything else leaves the pointer alone.
  always_comb begin
    grant   = 1'b0;
    illegal = 1'b0;
    rptr_d  = o_rptr;
    level_d = '0;
    grant   = i_ren && (i_rcnt != '0) && (rcnt_w <= MAX_RD) && (rcnt_w <= level_w);
    illegal = i_ren && ((rcnt_w > level_w) || (rcnt_w > MAX_RD));
    if (grant) begin
      rptr_d = PW'(32'(o_rptr) + rcnt_w);
    end
    level_d = PW'(ptr_diff(32'(i_wptr), 32'(rptr_d)));
  end

  assign o_ram_ren  = grant;
  assign o_ram_rcnt = grant ? i_rcnt : '0;
  assign o_raddr    = o_rptr[ALEN-1:0];

  // Level and flags follow the post-read pointer so a same-cycle write and read both land.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_rptr    <= '0;
      o_rlevel  <= '0;
      o_rempty  <= 1'b1;
      o_raempty <= 1'b1;
    end else begin
      o_rptr    <= rptr_d;
      o_rlevel  <= level_d;
      o_rempty  <= (level_d == '0);
      o_raempty <= (32'(level_d) <= AEMPTY_THRESH);
    end
  end

  // Sticky underflow; a new illegal request outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_runderflow <= 1'b0;
    end else if (illegal) begin
      o_runderflow <= 1'b1;
    end else if (i_uflow_clr) begin
      o_runderflow <= 1'b0;
    end
  end

`ifdef FIFO_RD_GRAY_PTR_EN
  ptr_bin2gray #(
    .W (PW)
  ) u_rptr_gray (
    .clk  (clk),
    .rstn (rstn),
    .bin  (rptr_d),
    .gray (o_rptr_gray)
  );
`endif

endmodule
